// File: rtl/midi_pkg.sv
// Shared MIDI definitions: nominal line rate and the receiver state encoding.
package midi_pkg;

  localparam int unsigned MIDI_BAUD = 31250;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop metastability synchronizer for an asynchronous input.
// Both flops clear to 1 so an idle-high line never looks active out of reset.
module sync2 (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 receiver: oversamples the synchronized line, samples mid-bit and
// emits each good byte with a one-cycle valid strobe; bad stop bits pulse frame_err.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = MIDI_BAUD,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic          rxs;
  rx_state_t     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    sh, sh_d;
  logic [7:0]    data_d;
  logic          valid_d, ferr_d;

  sync2 u_sync (
    .clk  (clk),
    .clr_n(clr_n),
    .d    (rx),
    .q    (rxs)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      sh        <= sh_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    sh_d    = sh;
    data_d  = data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else if (rxs) begin
          state_d = IDLE;
        end else begin
          cnt_d   = FULL_LOAD;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          sh_d[idx] = rxs;
          cnt_d     = FULL_LOAD;
          idx_d     = idx + 3'd1;
          if (idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          // Back to IDLE at mid-stop so a following start edge is not missed.
          if (rxs) begin
            data_d  = sh;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
